uart_rx_frame_sampler: RTL and testbench
========================================

// Module: uart_rx_frame_sampler
// PURPOSE
//  Synthesizable UART receive front end that feeds the master monitor BFM.
//  - Oversamples the serial line (16x) and recovers frames.
//  - Checks parity, stop bits and break conditions.
//  - Presents each decoded frame plus its error flags on a valid/ready port,
//    which the monitor BFM consumes and forwards to the monitor proxy.
// PARAMETERS
//  OVERSAMPLE  16  ticks per bit; mid-bit majority uses ticks 7,8,9
//  DIV_W       16  width of baud_div
//  DATA_MAX    8   widest data field; frame_data width
// PORTS
//  clk                input   1       single clock
//  rst                input   1       synchronous reset, active-high
//  rx_i               input   1       async serial line, idle high
//  baud_div           input   DIV_W   clk cycles per oversample tick; 0 treated as 1
//  cfg_data_bits      input   2       0..3 -> 5..8 data bits
//  cfg_parity_en      input   1       parity bit present
//  cfg_parity_odd     input   1       1=odd, 0=even
//  cfg_stop2          input   1       two stop bits
//  frame_valid        output  1       decoded frame held in output register
//  frame_ready        input   1       consumer accepts frame (valid&&ready)
//  frame_data         output  8       data, LSB first on line, zero-extended
//  frame_parity_err   output  1       parity mismatch (0 if parity disabled)
//  frame_framing_err  output  1       any stop bit sampled low
//  frame_break        output  1       break detected
//  overrun            output  1       1-cycle pulse: completed frame dropped
//  busy               output  1       FSM not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; sync flops = 1; tick counter = 0; FSM = IDLE.
//    Reset mid-frame discards the partial frame and any held frame.
//  - rx_i passes through a 2-flop synchronizer. All decisions use the synced value.
//  - Tick generator: counter runs from baud_div-1 down to 0 and emits a 1-clk tick.
//    It restarts on start-edge detection so sampling phase aligns to the edge.
//  - Bit sampling: each bit spans 16 ticks. The bit value is the majority of the
//    synced samples at ticks 7, 8 and 9; it is evaluated at tick 9.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
//    A break goes STOP1/STOP2 -> BRKWAIT -> IDLE.
//    - IDLE: a 1->0 transition on the synced line enters START.
//      cfg_* are latched at this point; mid-frame cfg changes are ignored.
//    - START: if the majority is 1 this is a false start; return to IDLE with no output.
//    - DATA: shift in N=5..8 bits, LSB first.
//    - PARITY: expected bit = XOR(data) ^ cfg_parity_odd; mismatch sets parity_err.
//    - STOP1/STOP2: a 0 sample sets framing_err. The frame completes at the
//      final stop bit's tick 9. The FSM then goes to IDLE, so a start edge
//      arriving in the remainder of the stop bit is detected.
//  - Break: data all 0, parity (if present) 0 and stop1 0.
//    Sets frame_break=1 and framing_err=1. The FSM waits in BRKWAIT until the line
//    is high, then returns to IDLE.
//  - Latency: frame_valid rises 1 clk after the completing sample.
//    Data and flags update in the same cycle.
//  - Output handshake: valid, data and flags are stable until valid&&ready.
//    valid drops the cycle after the handshake unless a new frame completes in
//    that same cycle; in that case the new frame loads and valid stays 1.
//  - Overrun: a frame that completes while valid && !ready is discarded and
//    overrun pulses for 1 clk. The held frame is unchanged.
//  - busy = (state != IDLE).
// TESTING
//  1) baud_div=4, 8N1, send 0x55 -> valid 1 clk after stop tick 9
//     (~9.5*64 clk after the start edge); data=0x55, all error flags 0.
//  2) 8E1, send 0xA3 with parity bit 1 (correct is 0) -> data=0xA3, parity_err=1,
//     framing_err=0.
//  3) 1-tick low glitch, and separately 6-tick low glitch, on idle line -> no frame;
//     busy returns to 0.
//  4) 8N1, line held low 20 bit times then high -> data=0x00, break=1, framing_err=1,
//     exactly one frame; the next 0x3C is received cleanly.
//  5) ready=0, two frames 0x11 then 0x22 -> held data stays 0x11, one overrun pulse;
//     raise ready -> 0x11 accepted, valid drops.
//  6) 7E2 with second stop bit low -> framing_err=1; rst asserted mid-DATA of the next
//     frame -> valid=0 and busy=0 next clk, no frame delivered.

Source files
------------

// File: rtl/uart_rx_frame_sampler.sv
// UART receive front end: 16x oversampled frame recovery with parity, framing and break
// detection, presenting each decoded frame on a valid/ready output register.
module uart_rx_frame_sampler #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DATA_MAX   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_i,
  input  logic [DIV_W-1:0]    baud_div,
  input  logic [1:0]          cfg_data_bits,
  input  logic                cfg_parity_en,
  input  logic                cfg_parity_odd,
  input  logic                cfg_stop2,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [DATA_MAX-1:0] frame_data,
  output logic                frame_parity_err,
  output logic                frame_framing_err,
  output logic                frame_break,
  output logic                overrun,
  output logic                busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_MAX);
  localparam int unsigned Mid   = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop1, StStop2, StBrkWait
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q, rx_prev_q;
  logic [DIV_W-1:0]    div_cnt_q, div_max;
  logic [TickW-1:0]    tick_idx_q;
  logic                s7_q, s8_q;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d, last_idx;
  logic [DATA_MAX-1:0] data_q, data_d;
  logic                par_bit_q, par_bit_d;
  logic                perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
  logic [1:0]          dbits_q;
  logic                par_en_q, par_odd_q, stop2_q;
  logic                rx_s, start_edge, tick_en, eval, bit_val, exp_par, is_brk, complete;

  logic                valid_q, out_perr_q, out_ferr_q, out_brk_q, overrun_q;
  logic [DATA_MAX-1:0] out_data_q;

  assign rx_s       = sync2_q;
  assign start_edge = (state_q == StIdle) && rx_prev_q && !rx_s;
  assign div_max    = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  assign tick_en    = (div_cnt_q == '0) && (state_q != StIdle);
  assign eval       = tick_en && (tick_idx_q == TickW'(Mid + 1));
  assign bit_val    = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
  assign exp_par    = (^data_q) ^ par_odd_q;
  assign last_idx   = BitW'(4) + BitW'(dbits_q);
  assign is_brk     = (data_q == '0) && !par_bit_q && !bit_val;

  // Synchronizer, edge history and tick generator; the divider restarts on the start edge
  // so the sampling phase is anchored to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      div_cnt_q  <= '0;
      tick_idx_q <= '0;
      s7_q       <= 1'b1;
      s8_q       <= 1'b1;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
      if (start_edge || div_cnt_q == '0) div_cnt_q <= div_max;
      else                               div_cnt_q <= div_cnt_q - DIV_W'(1);
      // The start edge itself is tick 0 of the start bit.
      if (start_edge) begin
        tick_idx_q <= TickW'(1);
      end else if (tick_en) begin
        if (tick_idx_q == TickW'(OVERSAMPLE - 1)) tick_idx_q <= '0;
        else                                      tick_idx_q <= tick_idx_q + TickW'(1);
        if (tick_idx_q == TickW'(Mid - 1)) s7_q <= rx_s;
        if (tick_idx_q == TickW'(Mid))     s8_q <= rx_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      dbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
      if (start_edge) begin
        dbits_q   <= cfg_data_bits;
        par_en_q  <= cfg_parity_en;
        par_odd_q <= cfg_parity_odd;
        stop2_q   <= cfg_stop2;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    brk_d     = brk_q;
    complete  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d   = StStart;
          bit_cnt_d = '0;
          data_d    = '0;
          par_bit_d = 1'b0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
          brk_d     = 1'b0;
        end
      end
      StStart: begin
        if (eval) state_d = bit_val ? StIdle : StData;
      end
      StData: begin
        if (eval) begin
          data_d[bit_cnt_q] = bit_val;
          if (bit_cnt_q == last_idx) state_d = par_en_q ? StParity : StStop1;
          else                       bit_cnt_d = bit_cnt_q + BitW'(1);
        end
      end
      StParity: begin
        if (eval) begin
          par_bit_d = bit_val;
          perr_d    = (bit_val != exp_par);
          state_d   = StStop1;
        end
      end
      StStop1: begin
        if (eval) begin
          ferr_d = !bit_val;
          brk_d  = is_brk;
          if (stop2_q) begin
            state_d = StStop2;
          end else begin
            complete = 1'b1;
            state_d  = is_brk ? StBrkWait : StIdle;
          end
        end
      end
      StStop2: begin
        if (eval) begin
          ferr_d   = ferr_q | !bit_val;
          complete = 1'b1;
          state_d  = brk_q ? StBrkWait : StIdle;
        end
      end
      StBrkWait: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A completing frame may load in the same cycle the held one is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      out_data_q <= '0;
      out_perr_q <= 1'b0;
      out_ferr_q <= 1'b0;
      out_brk_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (complete) begin
        if (!valid_q || frame_ready) begin
          valid_q    <= 1'b1;
          out_data_q <= data_d;
          out_perr_q <= perr_d;
          out_ferr_q <= ferr_d;
          out_brk_q  <= brk_d;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && frame_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign frame_valid       = valid_q;
  assign frame_data        = out_data_q;
  assign frame_parity_err  = out_perr_q;
  assign frame_framing_err = out_ferr_q;
  assign frame_break       = out_brk_q;
  assign overrun           = overrun_q;
  assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame_sampler.sv
// Self-checking bench for uart_rx_frame_sampler: directed vector table, multi-cycle corner
// sequences and random frames checked against a frame-level reference model.
module tb_uart_rx_frame_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_i;
  logic [15:0] baud_div;
  logic [1:0]  cfg_data_bits;
  logic        cfg_parity_en, cfg_parity_odd, cfg_stop2;
  logic        frame_valid, frame_ready;
  logic [7:0]  frame_data;
  logic        frame_parity_err, frame_framing_err, frame_break, overrun, busy;

  uart_rx_frame_sampler dut (
    .clk              (clk),
    .rst              (rst),
    .rx_i             (rx_i),
    .baud_div         (baud_div),
    .cfg_data_bits    (cfg_data_bits),
    .cfg_parity_en    (cfg_parity_en),
    .cfg_parity_odd   (cfg_parity_odd),
    .cfg_stop2        (cfg_stop2),
    .frame_valid      (frame_valid),
    .frame_ready      (frame_ready),
    .frame_data       (frame_data),
    .frame_parity_err (frame_parity_err),
    .frame_framing_err(frame_framing_err),
    .frame_break      (frame_break),
    .overrun          (overrun),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } res_t;

  typedef struct {
    int         div;
    logic [1:0] dbits;
    logic       pen, podd, s2;
    logic [7:0] data;
    logic       flip;
    logic       st1, st2;
    res_t       exp;
  } vec_t;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   start_cyc = 0;
  int   ovr_cnt = 0;
  logic valid_prev = 1'b0;
  res_t got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = frame_valid;
    if (!rst && frame_valid && frame_ready)
      got_q.push_back(res_t'({frame_data, frame_parity_err, frame_framing_err, frame_break}));
    if (!rst && overrun) ovr_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_rng(input string name, input int val, input int lo, input int hi);
    checks++;
    if (val >= lo && val <= hi) passes++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int len);
    rx_i = b;
    clks(len);
  endtask

  function automatic int bit_len(input int div);
    return 16 * ((div == 0) ? 1 : div);
  endfunction

  function automatic logic [7:0] masked(input vec_t v);
    int n;
    n = 5 + int'(v.dbits);
    return v.data & 8'((1 << n) - 1);
  endfunction

  // Frame-level model: what the receiver must report for the frame as placed on the line.
  function automatic res_t model(input vec_t v);
    res_t       r;
    logic [7:0] md;
    logic       pbit;
    md     = masked(v);
    pbit   = (^md) ^ v.podd ^ v.flip;
    r.data = md;
    r.perr = v.pen && (pbit != ((^md) ^ v.podd));
    r.ferr = !v.st1 || (v.s2 && !v.st2);
    r.brk  = (md == 8'h00) && (!v.pen || !pbit) && !v.st1;
    if (r.brk) r.ferr = 1'b1;
    return r;
  endfunction

  task automatic send_frame(input vec_t v);
    int         bl, n;
    logic [7:0] md;
    bl             = bit_len(v.div);
    n              = 5 + int'(v.dbits);
    md             = masked(v);
    baud_div       = 16'(v.div);
    cfg_data_bits  = v.dbits;
    cfg_parity_en  = v.pen;
    cfg_parity_odd = v.podd;
    cfg_stop2      = v.s2;
    start_cyc      = cyc;
    drive_bit(1'b0, bl);
    // Scramble cfg mid-frame: the receiver must use the values seen at the start edge.
    cfg_data_bits  = 2'($urandom);
    cfg_parity_en  = 1'($urandom);
    cfg_parity_odd = 1'($urandom);
    cfg_stop2      = 1'($urandom);
    for (int i = 0; i < n; i++) drive_bit(md[i], bl);
    if (v.pen) drive_bit((^md) ^ v.podd ^ v.flip, bl);
    drive_bit(v.st1, bl);
    if (v.s2) drive_bit(v.st2, bl);
    rx_i = 1'b1;
  endtask

  task automatic expect_one(input string name, input res_t exp);
    res_t r;
    chk({name, " count"}, got_q.size(), 1);
    if (got_q.size() == 1) begin
      r = got_q.pop_front();
      chk({name, " data"}, r.data, exp.data);
      chk({name, " parity_err"}, r.perr, exp.perr);
      chk({name, " framing_err"}, r.ferr, exp.ferr);
      chk({name, " break"}, r.brk, exp.brk);
    end
    got_q.delete();
  endtask

  function automatic vec_t mk(input int div, input logic [1:0] dbits, input logic pen,
                              input logic podd, input logic s2, input logic [7:0] data,
                              input logic flip, input logic st1, input logic st2,
                              input res_t exp);
    vec_t v;
    v.div = div; v.dbits = dbits; v.pen = pen; v.podd = podd; v.s2 = s2;
    v.data = data; v.flip = flip; v.st1 = st1; v.st2 = st2; v.exp = exp;
    return v;
  endfunction

  vec_t vecs[6];
  vec_t v;
  res_t e;

  initial begin
    //             div dbits pen odd s2 data  flip st1 st2  {data perr ferr brk}
    vecs[0] = mk(4, 2'd3, 0, 0, 0, 8'h55, 0, 1, 1, '{8'h55, 0, 0, 0});  // 8N1
    vecs[1] = mk(4, 2'd3, 1, 0, 0, 8'hA3, 1, 1, 1, '{8'hA3, 1, 0, 0});  // 8E1 bad parity
    vecs[2] = mk(2, 2'd2, 1, 0, 1, 8'h35, 0, 1, 0, '{8'h35, 0, 1, 0});  // 7E2, stop2 low
    vecs[3] = mk(1, 2'd0, 1, 1, 0, 8'hFF, 0, 1, 1, '{8'h1F, 0, 0, 0});  // 5O1, zero-extend
    vecs[4] = mk(3, 2'd1, 0, 0, 1, 8'h2A, 0, 0, 1, '{8'h2A, 0, 1, 0});  // 6N2, stop1 low
    vecs[5] = mk(0, 2'd3, 1, 1, 0, 8'h00, 0, 1, 1, '{8'h00, 0, 0, 0});  // 8O1, div 0

    rst = 1'b1; rx_i = 1'b1; baud_div = 16'd4; frame_ready = 1'b1;
    cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    clks(5);
    chk("reset valid", frame_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset outputs", {frame_data, frame_parity_err, frame_framing_err, frame_break,
                          overrun}, 0);
    rst = 1'b0;
    clks(20);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i]);
      clks(2 * bit_len(vecs[i].div));
      expect_one($sformatf("vec%0d", i), vecs[i].exp);
      if (i == 0) chk_rng("8N1 latency", rise_cyc - start_cyc, 9 * 64, 10 * 64);
    end

    // Short low glitches on an idle line are false starts.
    baud_div = 16'd4;
    drive_bit(1'b0, 4);
    rx_i = 1'b1;
    clks(2);
    chk("glitch1 busy", busy, 1);
    clks(80);
    chk("glitch1 busy after", busy, 0);
    drive_bit(1'b0, 24);
    rx_i = 1'b1;
    clks(80);
    chk("glitch6 busy after", busy, 0);
    chk("glitch frames", got_q.size(), 0);
    got_q.delete();

    // Break: line low for 20 bit times, then a clean frame.
    cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    drive_bit(1'b0, 20 * 64);
    rx_i = 1'b1;
    clks(128);
    expect_one("break", '{8'h00, 0, 1, 1});
    v = mk(4, 2'd3, 0, 0, 0, 8'h3C, 0, 1, 1, '{8'h3C, 0, 0, 0});
    send_frame(v);
    clks(128);
    expect_one("after break", v.exp);

    // Overrun: second frame dropped while the first is held.
    frame_ready = 1'b0;
    ovr_cnt = 0;
    send_frame(mk(2, 2'd3, 0, 0, 0, 8'h11, 0, 1, 1, '{8'h11, 0, 0, 0}));
    clks(64);
    send_frame(mk(2, 2'd3, 0, 0, 0, 8'h22, 0, 1, 1, '{8'h22, 0, 0, 0}));
    clks(64);
    chk("ovr valid held", frame_valid, 1);
    chk("ovr data held", frame_data, 8'h11);
    chk("ovr pulses", ovr_cnt, 1);
    frame_ready = 1'b1;
    clks(1);
    chk("ovr valid drops", frame_valid, 0);
    expect_one("ovr accepted", '{8'h11, 0, 0, 0});

    // Reset mid-frame while a frame is held.
    frame_ready = 1'b0;
    send_frame(vecs[2]);
    clks(64);
    chk("rst held valid", frame_valid, 1);
    chk("rst held ferr", frame_framing_err, 1);
    baud_div = 16'd2; cfg_data_bits = 2'd2; cfg_parity_en = 1'b1; cfg_stop2 = 1'b1;
    drive_bit(1'b0, 32);
    drive_bit(1'b1, 32);
    drive_bit(1'b0, 16);
    chk("rst pre busy", busy, 1);
    rst = 1'b1;
    clks(1);
    chk("rst valid", frame_valid, 0);
    chk("rst busy", busy, 0);
    rst = 1'b0;
    rx_i = 1'b1;
    frame_ready = 1'b1;
    clks(200);
    chk("rst no frame", got_q.size(), 0);
    got_q.delete();

    // Random frames against the model.
    for (int i = 0; i < 40; i++) begin
      v.div   = int'($urandom_range(0, 3));
      v.dbits = 2'($urandom);
      v.pen   = 1'($urandom);
      v.podd  = 1'($urandom);
      v.s2    = 1'($urandom);
      v.data  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      v.flip  = ($urandom_range(0, 3) == 0);
      v.st1   = ($urandom_range(0, 4) != 0);
      v.st2   = ($urandom_range(0, 4) != 0);
      e = model(v);
      send_frame(v);
      clks(2 * bit_len(v.div));
      chk($sformatf("rand%0d count", i), got_q.size(), 1);
      if (got_q.size() == 1) chk($sformatf("rand%0d frame", i), got_q.pop_front(), e);
      got_q.delete();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
